// File: rtl/alu_flag_unit_pkg.sv
// Shared definitions for the ALU flag unit: FSM states, opcode encodings and
// opcode classification helpers.
package alu_flag_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } alu_state_t;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_PASSA = 4'h6;
  localparam logic [3:0] OP_PASSB = 4'h7;
  localparam logic [3:0] OP_SLL   = 4'h8;
  localparam logic [3:0] OP_SRL   = 4'h9;
  localparam logic [3:0] OP_SRA   = 4'hA;
  localparam logic [3:0] OP_ROL   = 4'hB;
  localparam logic [3:0] OP_ROR   = 4'hC;

  // Rotates only count as shifts when the rotate feature is built in.
  function automatic logic is_shift_op(input logic [3:0] op, input logic rot_en);
    return (op inside {OP_SLL, OP_SRL, OP_SRA}) ||
           (rot_en && (op inside {OP_ROL, OP_ROR}));
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op, input logic rot_en);
    return (op <= OP_PASSB) || is_shift_op(op, rot_en);
  endfunction

endpackage

// File: rtl/alu_flag_unit_addsub.sv
// Combinational adder/subtractor: sum, carry-out (no-borrow on subtract) and
// two's-complement overflow.
module alu_addsub #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] i_a,
  input  logic [DATAWIDTH-1:0] i_b,
  input  logic                 i_sub,
  output logic [DATAWIDTH-1:0] o_sum,
  output logic                 o_carry,
  output logic                 o_overflow
);

  logic [DATAWIDTH-1:0] w_b;

  // Subtract as A + ~B + 1 so the carry-out is the unsigned no-borrow flag.
  assign w_b = i_sub ? ~i_b : i_b;
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{DATAWIDTH{1'b0}}, i_sub};
  assign o_overflow = (i_a[DATAWIDTH-1] == w_b[DATAWIDTH-1]) &&
                      (o_sum[DATAWIDTH-1] != i_a[DATAWIDTH-1]);

endmodule

// File: rtl/alu_flag_unit.sv
// Multi-cycle ALU with V/N/C/Z flags and a SetCodes strobe for the status register.
// Define ALU_ROTATE_EN to enable ROL/ROR; otherwise those opcodes are illegal.
module alu_flag_unit
  import alu_flag_unit_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int OPWIDTH   = 4
) (
  input  logic                 ALU_CLOCK_50,
  input  logic                 ALU_ResetInLow_In,
  input  logic                 ALU_Start_In,
  input  logic [OPWIDTH-1:0]   ALU_Op_InBus,
  input  logic [DATAWIDTH-1:0] ALU_DataA_InBus,
  input  logic [DATAWIDTH-1:0] ALU_DataB_InBus,
  input  logic                 ALU_SetCodesReq_In,
  output logic                 ALU_Busy_Out,
  output logic                 ALU_Done_Out,
  output logic [DATAWIDTH-1:0] ALU_Result_OutBus,
  output logic                 ALU_FlagOverflow_Out,
  output logic                 ALU_FlagNegative_Out,
  output logic                 ALU_FlagCarry_Out,
  output logic                 ALU_FlagZero_Out,
  output logic                 ALU_SetCodes_Out
);

  localparam int SHW = $clog2(DATAWIDTH);
`ifdef ALU_ROTATE_EN
  localparam logic ROT_EN = 1'b1;
`else
  localparam logic ROT_EN = 1'b0;
`endif

  alu_state_t           r_state, w_next;
  logic [OPWIDTH-1:0]   r_op;
  logic [DATAWIDTH-1:0] r_a, r_b, r_result;
  logic                 r_req, r_v, r_n, r_c, r_z;
  logic [SHW-1:0]       r_cnt;

  logic [3:0]           w_op4;
  logic                 w_legal, w_shift, w_accept;
  logic [SHW-1:0]       w_amt;
  logic [DATAWIDTH-1:0] w_sum, w_res, w_step;
  logic                 w_cout, w_ovf, w_c, w_v, w_shout;

  assign w_op4    = 4'(r_op);
  assign w_legal  = (OPWIDTH'(w_op4) == r_op) && is_legal_op(w_op4, ROT_EN);
  assign w_shift  = (OPWIDTH'(w_op4) == r_op) && is_shift_op(w_op4, ROT_EN);
  assign w_amt    = r_b[SHW-1:0];
  assign w_accept = (r_state == ST_IDLE) && ALU_Start_In;

  alu_addsub #(.DATAWIDTH(DATAWIDTH)) u_addsub (
    .i_a        (r_a),
    .i_b        (r_b),
    .i_sub      (w_op4 == OP_SUB),
    .o_sum      (w_sum),
    .o_carry    (w_cout),
    .o_overflow (w_ovf)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_res = r_a;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op4)
      OP_ADD, OP_SUB: begin
        w_res = w_sum;
        w_c   = w_cout;
        w_v   = w_ovf;
      end
      OP_AND:   w_res = r_a & r_b;
      OP_OR:    w_res = r_a | r_b;
      OP_XOR:   w_res = r_a ^ r_b;
      OP_NOT:   w_res = ~r_a;
      OP_PASSB: w_res = r_b;
      default:  w_res = r_a;  // PASS A, and any shift by zero
    endcase
  end

  // One bit of shift/rotate per SHIFT cycle; r_a is the working register.
  always_comb begin
    w_step  = r_a;
    w_shout = 1'b0;
    case (w_op4)
      OP_SLL: begin w_step = {r_a[DATAWIDTH-2:0], 1'b0};           w_shout = r_a[DATAWIDTH-1]; end
      OP_SRL: begin w_step = {1'b0, r_a[DATAWIDTH-1:1]};           w_shout = r_a[0];           end
      OP_SRA: begin w_step = {r_a[DATAWIDTH-1], r_a[DATAWIDTH-1:1]}; w_shout = r_a[0];         end
      OP_ROL: begin w_step = {r_a[DATAWIDTH-2:0], r_a[DATAWIDTH-1]}; w_shout = r_a[DATAWIDTH-1]; end
      OP_ROR: begin w_step = {r_a[0], r_a[DATAWIDTH-1:1]};         w_shout = r_a[0];           end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge ALU_CLOCK_50 or negedge ALU_ResetInLow_In) begin
    if (!ALU_ResetInLow_In) r_state <= ST_IDLE;
    else                    r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (ALU_Start_In) w_next = ST_EXEC;
      ST_EXEC:  w_next = (w_legal && w_shift && (w_amt != '0)) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (r_cnt == SHW'(1)) w_next = ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ALU_Busy_Out     = (r_state != ST_IDLE);
    ALU_Done_Out     = (r_state == ST_DONE);
    ALU_SetCodes_Out = (r_state == ST_DONE) && r_req && w_legal;
  end

  always_ff @(posedge ALU_CLOCK_50 or negedge ALU_ResetInLow_In) begin
    if (!ALU_ResetInLow_In) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_req    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_v      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= ALU_Op_InBus;
        r_a   <= ALU_DataA_InBus;
        r_b   <= ALU_DataB_InBus;
        r_req <= ALU_SetCodesReq_In;
      end
      case (r_state)
        ST_EXEC: if (w_legal) begin
          if (w_shift && (w_amt != '0)) begin
            r_cnt <= w_amt;
          end else begin
            r_result <= w_res;
            r_v      <= w_v;
            r_c      <= w_c;
            r_n      <= w_res[DATAWIDTH-1];
            r_z      <= (w_res == '0);
          end
        end
        ST_SHIFT: begin
          r_a   <= w_step;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == SHW'(1)) begin
            r_result <= w_step;
            r_v      <= 1'b0;
            r_c      <= w_shout;
            r_n      <= w_step[DATAWIDTH-1];
            r_z      <= (w_step == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign ALU_Result_OutBus    = r_result;
  assign ALU_FlagOverflow_Out = r_v;
  assign ALU_FlagNegative_Out = r_n;
  assign ALU_FlagCarry_Out    = r_c;
  assign ALU_FlagZero_Out     = r_z;

endmodule
